// File: rtl/hv_bundle_ctrl.sv
// -----------------------------------------------------------------------------
// hv_bundle_ctrl
//
// Bundling controller for the HPU bipolar datapath. Incoming core-result beats
// are mapped lane by lane onto bipolar values:
//   store=1, bit=0 -> +1
//   store=1, bit=1 -> -1
//   store=0        ->  0
// These values are summed per lane in saturating signed accumulators. After
// the last beat the sums are majority-voted into a binary bundled
// hypervector, which is then held until the item-memory write path takes it.
//
// Sequencing: ACCUM -> THRESH -> HOLD -> ACCUM. Only one bundle is in flight
// at a time.
//
// Parameters
//   DIM    number of hypervector lanes per beat
//   CNT_W  signed accumulator width per lane (>= 2)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort; zeroes the accumulators and the beat count
//              and returns to ACCUM. A beat offered in the same cycle is
//              dropped.
//   in_valid   beat valid
//   in_ready   beat accepted when in_valid & in_ready (high only in ACCUM)
//   in_bits    core result bits, one per lane
//   in_store   1: the beat contributes +/-1 per lane; 0: it contributes 0
//              (the beat is still counted)
//   in_last    marks the final beat of the bundle
//   tie_bits   tie-break vector for lanes whose sum is zero; sampled in THRESH
//   out_valid  bundled vector valid
//   out_ready  consumer accepts when out_valid & out_ready
//   out_bits   bundled hypervector
//   beat_cnt   beats accepted in the current bundle, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module hv_bundle_ctrl #(
    parameter int DIM   = 32,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DIM-1:0]  in_bits,
    input  logic            in_store,
    input  logic            in_last,
    input  logic [DIM-1:0]  tie_bits,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DIM-1:0]  out_bits,
    output logic [15:0]     beat_cnt
);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_THRESH = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Accumulator limits, expressed one bit wider than the accumulator so the
    // unclamped sum can be compared against them without overflowing.
    localparam logic signed [CNT_W:0] ACC_MAX = {2'b00, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W:0] ACC_MIN = {2'b11, {(CNT_W-1){1'b0}}};

    state_t                  state;
    logic signed [CNT_W-1:0] acc [DIM];

    // Bipolar value that one lane of a beat contributes to its accumulator.
    function automatic logic signed [1:0] lane_value(input logic store,
                                                     input logic bit_in);
        if (!store)
            return 2'sb00;
        else if (bit_in)
            return 2'sb11;      // -1
        else
            return 2'sb01;      // +1
    endfunction

    // Saturating add. The sum is formed one bit wider and clamped back into
    // the accumulator range, so a lane pinned at a limit stays there instead
    // of wrapping to the opposite sign.
    function automatic logic signed [CNT_W-1:0] sat_add(
        input logic signed [CNT_W-1:0] a,
        input logic signed [1:0]       v
    );
        logic signed [CNT_W:0] s;
        s = {a[CNT_W-1], a} + {{(CNT_W-1){v[1]}}, v};
        if (s > ACC_MAX)
            s = ACC_MAX;
        else if (s < ACC_MIN)
            s = ACC_MIN;
        return s[CNT_W-1:0];
    endfunction

    // Majority vote for one lane: a negative sum means the -1 (bit=1) votes
    // won, a positive sum means the +1 (bit=0) votes won, and an exact tie
    // takes the caller-supplied tie bit.
    function automatic logic vote(input logic signed [CNT_W-1:0] a,
                                  input logic                    tie);
        if (a < 0)
            return 1'b1;
        else if (a > 0)
            return 1'b0;
        else
            return tie;
    endfunction

    // Beat counter increment that sticks at all-ones.
    function automatic logic [15:0] cnt_inc(input logic [15:0] c);
        if (c == 16'hFFFF)
            return c;
        else
            return c + 16'd1;
    endfunction

    // Beats are accepted only in ACCUM. Deriving in_ready from the state
    // register alone keeps it free of any path from in_valid or out_ready.
    assign in_ready = (state == ST_ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACCUM;
            out_valid <= 1'b0;
            out_bits  <= '0;
            beat_cnt  <= '0;
            for (int i = 0; i < DIM; i++)
                acc[i] <= '0;
        end else if (clear) begin
            // Abort wins over everything. out_bits deliberately keeps its
            // last value; out_valid going low is what withdraws it.
            state     <= ST_ACCUM;
            out_valid <= 1'b0;
            beat_cnt  <= '0;
            for (int i = 0; i < DIM; i++)
                acc[i] <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        for (int i = 0; i < DIM; i++)
                            acc[i] <= sat_add(acc[i], lane_value(in_store, in_bits[i]));
                        beat_cnt <= cnt_inc(beat_cnt);
                        if (in_last)
                            state <= ST_THRESH;
                    end
                end

                ST_THRESH: begin
                    for (int i = 0; i < DIM; i++)
                        out_bits[i] <= vote(acc[i], tie_bits[i]);
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end

                ST_HOLD: begin
                    // out_bits and beat_cnt stay frozen until the consumer
                    // takes the vector.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        beat_cnt  <= '0;
                        for (int i = 0; i < DIM; i++)
                            acc[i] <= '0;
                        state <= ST_ACCUM;
                    end
                end

                default: begin
                    state     <= ST_ACCUM;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hv_bundle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hv_bundle_ctrl
//
// Directed testbench for hv_bundle_ctrl with DIM=4 and CNT_W=4. Inputs are
// driven 1 time unit after the rising edge and outputs are sampled at that
// same point, clear of the active edge.
// -----------------------------------------------------------------------------
module tb_hv_bundle_ctrl;

    localparam int DIM   = 4;
    localparam int CNT_W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear;
    logic           in_valid;
    logic           in_ready;
    logic [DIM-1:0] in_bits;
    logic           in_store;
    logic           in_last;
    logic [DIM-1:0] tie_bits;
    logic           out_valid;
    logic           out_ready;
    logic [DIM-1:0] out_bits;
    logic [15:0]    beat_cnt;

    int tests = 0;
    int fails = 0;

    hv_bundle_ctrl #(.DIM(DIM), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .in_store  (in_store),
        .in_last   (in_last),
        .tie_bits  (tie_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat for exactly one cycle (caller knows in_ready is high).
    task automatic beat(input logic [DIM-1:0] b, input logic st, input logic last);
        in_valid = 1'b1;
        in_bits  = b;
        in_store = st;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the last beat: checks the 2-cycle latency and result.
    task automatic expect_result(input string tag, input logic [DIM-1:0] exp_bits,
                                 input logic [15:0] exp_cnt);
        check({tag, "_thresh_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_thresh_ready"}, 32'(in_ready), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_bits"},  32'(out_bits), 32'(exp_bits));
        check({tag, "_cnt"},   32'(beat_cnt), 32'(exp_cnt));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_hs_cnt"},   32'(beat_cnt), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_bits   = '0;
        in_store  = 1'b1;
        in_last   = 1'b0;
        tie_bits  = '0;
        out_ready = 1'b0;

        // ---- reset ----
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bits",  32'(out_bits),  32'd0);
        check("rst_cnt",   32'(beat_cnt),  32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        // ---- basic majority: 0011, 0101, 0110 -> 0111 ----
        beat(4'b0011, 1'b1, 1'b0);
        beat(4'b0101, 1'b1, 1'b0);
        check("basic_cnt_mid", 32'(beat_cnt), 32'd2);
        beat(4'b0110, 1'b1, 1'b1);
        expect_result("basic", 4'b0111, 16'd3);
        handshake("basic");

        // ---- tie: 1111, 0000 -> tie_bits ----
        tie_bits = 4'b1010;
        beat(4'b1111, 1'b1, 1'b0);
        beat(4'b0000, 1'b1, 1'b1);
        expect_result("tie", 4'b1010, 16'd2);
        handshake("tie");

        // ---- saturation: 10x 0000 clamps at +7, 7x 1111 brings it to 0 ----
        tie_bits = 4'b0110;
        for (int i = 0; i < 10; i++)
            beat(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++)
            beat(4'b1111, 1'b1, (i == 6));
        expect_result("sat", 4'b0110, 16'd17);
        handshake("sat");

        // ---- store masking ----
        tie_bits = 4'b1111;
        for (int i = 0; i < 3; i++)
            beat(4'b1111, 1'b0, 1'b0);
        beat(4'b0000, 1'b1, 1'b1);
        expect_result("mask", 4'b0000, 16'd4);

        // ---- backpressure in HOLD ----
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_bits  = 4'b1111;
            in_last  = 1'b1;
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_bits",  32'(out_bits),  32'd0);
            check("bp_ready", 32'(in_ready),  32'd0);
            check("bp_cnt",   32'(beat_cnt),  32'd4);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake("bp");
        beat(4'b1000, 1'b1, 1'b1);
        expect_result("bp_next", 4'b1000, 16'd1);
        handshake("bp_next");

        // ---- clear mid-bundle, with a beat offered in the clear cycle ----
        tie_bits = 4'b0000;
        beat(4'b1111, 1'b1, 1'b0);
        beat(4'b1111, 1'b1, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_bits  = 4'b1111;
        in_last  = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("clr_cnt",   32'(beat_cnt), 32'd0);
        check("clr_ready", 32'(in_ready), 32'd1);
        check("clr_valid", 32'(out_valid), 32'd0);
        beat(4'b0001, 1'b1, 1'b1);
        expect_result("clr", 4'b0001, 16'd1);
        handshake("clr");

        // ---- reset during HOLD ----
        beat(4'b0110, 1'b1, 1'b1);
        expect_result("rhold", 4'b0110, 16'd1);
        rst_n = 1'b0;
        #1;
        check("rhold_valid", 32'(out_valid), 32'd0);
        check("rhold_cnt",   32'(beat_cnt),  32'd0);
        check("rhold_bits",  32'(out_bits),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rhold_ready", 32'(in_ready), 32'd1);
        // A fresh bundle after reset starts from zeroed accumulators.
        tie_bits = 4'b1001;
        beat(4'b0000, 1'b0, 1'b1);
        expect_result("rhold_next", 4'b1001, 16'd1);
        handshake("rhold_next");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
